// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the SRAM / memory-mapped I/O controller.
// Strobes are active-low, so the inactive level is a logic one.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        IO     = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic STROBE_OFF = 1'b1;
    localparam int   WAIT_W     = 4;

endpackage

// File: rtl/mem_wait_cnt.sv
// Wait-state down-counter: load presets WAIT, then counts down to zero and holds there.
// Latency: value updates one edge after load; done is combinational from the count.
module mem_wait_cnt
    import mem_ctrl_pkg::*;
#(
    parameter int WAIT = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              load,
    output logic [WAIT_W-1:0] value,
    output logic              done
);

    logic [WAIT_W-1:0] r_value;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_value <= '0;
        end else if (load) begin
            r_value <= WAIT_W'(WAIT);
        end else if (r_value != '0) begin
            r_value <= r_value - WAIT_W'(1);
        end
    end

    assign value = r_value;
    assign done  = (r_value == '0);

endmodule

// File: rtl/mem_ctrl.sv
// Single-outstanding CPU-to-async-SRAM controller with one memory-mapped I/O address.
// ack arrives WAIT+2 cycles after acceptance (2 for I/O); requests while busy are dropped.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int             DW      = 16,
    parameter int             AW      = 20,
    parameter int             WAIT    = 2,
    parameter logic [AW-1:0]  IO_ADDR = 'hFFFF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DW-1:0]     wdata,
    input  logic [DW/8-1:0]   be,
    output logic [DW-1:0]     rdata,
    output logic              ack,
    output logic              busy,
    output logic              Mem_CE,
    output logic              Mem_OE,
    output logic              Mem_WE,
    output logic [DW/8-1:0]   Mem_BE,
    output logic [AW-1:0]     ADDR,
    inout  wire  [DW-1:0]     Data,
    input  logic [DW-1:0]     Switches,
    output logic [DW-1:0]     HexOut
);

    localparam int BW = DW / 8;

    state_t            r_state;
    state_t            w_state_next;

    logic              w_accept;
    logic              w_to_io;
    logic              w_acc_end;
    logic              w_io_end;
    logic              w_cnt_load;
    logic              w_cnt_done;
    logic [WAIT_W-1:0] w_cnt_value;

    logic              r_we;
    logic [DW-1:0]     r_wdata;
    logic [BW-1:0]     r_be;
    logic [DW-1:0]     r_rdata;
    logic              r_ack;
    logic              r_busy;
    logic              r_ce;
    logic              r_oe;
    logic              r_mem_we;
    logic [BW-1:0]     r_mem_be;
    logic [AW-1:0]     r_addr;
    logic [DW-1:0]     r_hex;
    logic              r_drive;
    logic [DW-1:0]     w_hex_merged;

    mem_wait_cnt #(
        .WAIT (WAIT)
    ) u_wait_cnt (
        .Clk   (Clk),
        .Reset (Reset),
        .load  (w_cnt_load),
        .value (w_cnt_value),
        .done  (w_cnt_done)
    );

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_to_io      = 1'b0;
        w_acc_end    = 1'b0;
        w_io_end     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (req) begin
                    w_accept = 1'b1;
                    if (addr == IO_ADDR) begin
                        w_to_io      = 1'b1;
                        w_state_next = IO;
                    end else begin
                        w_state_next = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (w_cnt_done) begin
                    w_acc_end    = 1'b1;
                    w_state_next = DONE;
                end
            end
            IO: begin
                w_io_end     = 1'b1;
                w_state_next = DONE;
            end
            DONE: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign w_cnt_load = w_accept && !w_to_io;

    always_comb begin
        w_hex_merged = r_hex;
        for (int b = 0; b < BW; b++) begin
            if (r_be[b]) begin
                w_hex_merged[8*b +: 8] = r_wdata[8*b +: 8];
            end
        end
    end

    // Strobes are registered, so each is set on the edge that enters the cycle it applies to.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_we     <= 1'b0;
            r_wdata  <= '0;
            r_be     <= '0;
            r_rdata  <= '0;
            r_ack    <= 1'b0;
            r_busy   <= 1'b0;
            r_ce     <= STROBE_OFF;
            r_oe     <= STROBE_OFF;
            r_mem_we <= STROBE_OFF;
            r_mem_be <= {BW{STROBE_OFF}};
            r_addr   <= '0;
            r_hex    <= '0;
            r_drive  <= 1'b0;
        end else begin
            r_ack <= w_acc_end || w_io_end;

            if (w_accept) begin
                r_busy  <= 1'b1;
                r_we    <= we;
                r_wdata <= wdata;
                r_be    <= be;
            end else if (r_state == DONE) begin
                r_busy  <= 1'b0;
            end

            if (w_cnt_load) begin
                r_addr   <= addr;
                r_ce     <= 1'b0;
                r_oe     <= we;
                r_mem_we <= !we;
                r_mem_be <= ~be;
                r_drive  <= we;
            end else if (w_acc_end) begin
                r_ce     <= STROBE_OFF;
                r_oe     <= STROBE_OFF;
                r_mem_we <= STROBE_OFF;
                r_mem_be <= {BW{STROBE_OFF}};
                r_drive  <= 1'b0;
                if (!r_we) begin
                    r_rdata <= Data;
                end
            end else if (r_state == ACCESS && w_cnt_value == WAIT_W'(1)) begin
                // Release WE one cycle early so data is held past the write strobe.
                r_mem_we <= STROBE_OFF;
            end

            if (w_io_end) begin
                if (r_we) begin
                    r_hex   <= w_hex_merged;
                end else begin
                    r_rdata <= Switches;
                end
            end
        end
    end

    assign Data   = r_drive ? r_wdata : {DW{1'bz}};
    assign rdata  = r_rdata;
    assign ack    = r_ack;
    assign busy   = r_busy;
    assign Mem_CE = r_ce;
    assign Mem_OE = r_oe;
    assign Mem_WE = r_mem_we;
    assign Mem_BE = r_mem_be;
    assign ADDR   = r_addr;
    assign HexOut = r_hex;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: default build with an SRAM model plus two DW=32/AW=18
// builds at WAIT=1 and WAIT=15 for latency and strobe-width checks.
`timescale 1ns/1ps
module tb_mem_ctrl;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        Reset;
    logic        req, we;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] rdata, Switches, HexOut;
    logic        ack, busy, ce, oe, wem;
    logic [1:0]  mbe;
    logic [19:0] ADDR;
    wire  [15:0] Data;

    logic [15:0] mem [0:255];

    int n_chk = 0;
    int n_bad = 0;

    mem_ctrl #(.DW(16), .AW(20), .WAIT(2), .IO_ADDR(20'hFFFF)) u_dut (
        .Clk(Clk), .Reset(Reset), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .rdata(rdata), .ack(ack), .busy(busy), .Mem_CE(ce), .Mem_OE(oe), .Mem_WE(wem),
        .Mem_BE(mbe), .ADDR(ADDR), .Data(Data), .Switches(Switches), .HexOut(HexOut)
    );

    // Async SRAM model: combinational read, byte-lane write while CE and WE are low.
    assign Data = (!ce && !oe && wem) ? mem[ADDR[7:0]] : 16'hzzzz;

    always @(posedge Clk) begin
        if (!Reset) begin
            for (int i = 0; i < 256; i++)
                mem[i] <= (i == 'h42) ? 16'h1234 : {8'h55, 8'(i)};
        end else if (!ce && !wem) begin
            for (int b = 0; b < 2; b++)
                if (!mbe[b]) mem[ADDR[7:0]][8*b +: 8] <= Data[8*b +: 8];
        end
    end

    // Parameter sweep instances share stimulus.
    logic        s_req, s_we;
    logic [17:0] s_addr;
    logic [31:0] s_wdata, s_sw;
    logic [3:0]  s_be;
    logic [31:0] s1_rdata, s15_rdata, s1_hex, s15_hex;
    logic        s1_ack, s1_busy, s1_ce, s1_oe, s1_we;
    logic        s15_ack, s15_busy, s15_ce, s15_oe, s15_we;
    logic [3:0]  s1_mbe, s15_mbe;
    logic [17:0] s1_addr_o, s15_addr_o;
    wire  [31:0] s1_data, s15_data;

    mem_ctrl #(.DW(32), .AW(18), .WAIT(1)) u_w1 (
        .Clk(Clk), .Reset(Reset), .req(s_req), .we(s_we), .addr(s_addr), .wdata(s_wdata), .be(s_be),
        .rdata(s1_rdata), .ack(s1_ack), .busy(s1_busy), .Mem_CE(s1_ce), .Mem_OE(s1_oe), .Mem_WE(s1_we),
        .Mem_BE(s1_mbe), .ADDR(s1_addr_o), .Data(s1_data), .Switches(s_sw), .HexOut(s1_hex)
    );

    mem_ctrl #(.DW(32), .AW(18), .WAIT(15)) u_w15 (
        .Clk(Clk), .Reset(Reset), .req(s_req), .we(s_we), .addr(s_addr), .wdata(s_wdata), .be(s_be),
        .rdata(s15_rdata), .ack(s15_ack), .busy(s15_busy), .Mem_CE(s15_ce), .Mem_OE(s15_oe), .Mem_WE(s15_we),
        .Mem_BE(s15_mbe), .ADDR(s15_addr_o), .Data(s15_data), .Switches(s_sw), .HexOut(s15_hex)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called #1 after an edge with the DUT idle; returns one cycle after ack (DUT idle again).
    task automatic run_access(input logic t_we, input logic [19:0] t_addr, input logic [15:0] t_wdata,
                              input logic [1:0] t_be, output int lat, output int ce_n, output int oe_n,
                              output int we_n, output int dat_n, output logic last_we,
                              output logic [1:0] be_seen);
        lat = 0; ce_n = 0; oe_n = 0; we_n = 0; dat_n = 0; last_we = 1'b0; be_seen = 2'b11;
        req = 1'b1; we = t_we; addr = t_addr; wdata = t_wdata; be = t_be;
        @(posedge Clk); #1;
        req = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (!ce) begin
                ce_n++;
                last_we = wem;
                be_seen = mbe;
                if (Data === t_wdata) dat_n++;
            end
            if (!oe)  oe_n++;
            if (!wem) we_n++;
            if (ack) begin
                lat = k;
                break;
            end
            @(posedge Clk); #1;
        end
        @(posedge Clk); #1;
    endtask

    task automatic run_sweep(input logic t_we, input logic [17:0] t_addr, input logic [31:0] t_wdata,
                             output int lat1, output int lat15, output int ce1, output int ce15,
                             output int wl1, output int wl15, output int d1, output int d15);
        lat1 = 0; lat15 = 0; ce1 = 0; ce15 = 0; wl1 = 0; wl15 = 0; d1 = 0; d15 = 0;
        s_req = 1'b1; s_we = t_we; s_addr = t_addr; s_wdata = t_wdata; s_be = 4'hF;
        @(posedge Clk); #1;
        s_req = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (lat1 == 0) begin
                if (!s1_ce) ce1++;
                if (!s1_we) wl1++;
                if (!s1_ce && s1_data === t_wdata) d1++;
                if (s1_ack) lat1 = k;
            end
            if (lat15 == 0) begin
                if (!s15_ce) ce15++;
                if (!s15_we) wl15++;
                if (!s15_ce && s15_data === t_wdata) d15++;
                if (s15_ack) lat15 = k;
            end
            if (lat1 != 0 && lat15 != 0) break;
            @(posedge Clk); #1;
        end
        @(posedge Clk); #1;
    endtask

    int          lat, ce_n, oe_n, we_n, dat_n, nack, nwe, a1, a2;
    int          l1, l15, c1, c15, w1, w15, d1, d15;
    logic        last_we;
    logic [1:0]  be_seen;

    initial begin
        Reset = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0; Switches = 16'h00A5;
        s_req = 1'b0; s_we = 1'b0; s_addr = '0; s_wdata = '0; s_be = '0; s_sw = 32'hCAFE_0001;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_ce", ce, 1); check("rst_oe", oe, 1); check("rst_we", wem, 1);
        check("rst_be", mbe, 2'b11); check("rst_addr", ADDR, 0); check("rst_rdata", rdata, 0);
        check("rst_hex", HexOut, 0); check("rst_ack", ack, 0); check("rst_busy", busy, 0);
        check("rst_data_z", (Data === 16'hzzzz), 1);
        Reset = 1'b1;
        @(posedge Clk); #1;

        run_access(1'b0, 20'h00042, 16'h0000, 2'b11, lat, ce_n, oe_n, we_n, dat_n, last_we, be_seen);
        check("rd_lat", lat, 4); check("rd_oe_low", oe_n, 3); check("rd_ce_low", ce_n, 3);
        check("rd_we_low", we_n, 0); check("rd_rdata", rdata, 16'h1234); check("rd_busy_end", busy, 0);

        run_access(1'b1, 20'h00010, 16'hBEEF, 2'b01, lat, ce_n, oe_n, we_n, dat_n, last_we, be_seen);
        check("wr_lat", lat, 4); check("wr_we_low", we_n, 2); check("wr_we_hold", last_we, 1);
        check("wr_oe_low", oe_n, 0); check("wr_mem_be", be_seen, 2'b10); check("wr_data", dat_n, 3);
        check("wr_mem", mem[8'h10], 16'h55EF); check("wr_data_z", (Data === 16'hzzzz), 1);

        run_access(1'b1, 20'h00020, 16'h1111, 2'b00, lat, ce_n, oe_n, we_n, dat_n, last_we, be_seen);
        check("be0_lat", lat, 4); check("be0_ce_low", ce_n, 3); check("be0_mem_be", be_seen, 2'b11);
        check("be0_mem", mem[8'h20], 16'h5520);

        run_access(1'b0, 20'hFFFF, 16'h0000, 2'b11, lat, ce_n, oe_n, we_n, dat_n, last_we, be_seen);
        check("io_rd_lat", lat, 2); check("io_rd_ce", ce_n, 0); check("io_rd_oe", oe_n, 0);
        check("io_rd_rdata", rdata, 16'h00A5);

        run_access(1'b1, 20'hFFFF, 16'h1234, 2'b11, lat, ce_n, oe_n, we_n, dat_n, last_we, be_seen);
        check("io_wr_lat", lat, 2); check("io_wr_we", we_n, 0); check("io_wr_hex", HexOut, 16'h1234);

        run_access(1'b1, 20'hFFFF, 16'hABCD, 2'b10, lat, ce_n, oe_n, we_n, dat_n, last_we, be_seen);
        check("io_wr_merge", HexOut, 16'hAB34);

        // req held high: ack every WAIT+3 cycles because DONE never accepts.
        nack = 0; a1 = 0; a2 = 0;
        req = 1'b1; we = 1'b0; addr = 20'h00042;
        for (int i = 1; i <= 12; i++) begin
            @(posedge Clk); #1;
            if (ack) begin
                nack++;
                if (a1 == 0) a1 = i; else if (a2 == 0) a2 = i;
            end
        end
        req = 1'b0;
        repeat (6) @(posedge Clk);
        #1;
        check("b2b_acks", nack, 2); check("b2b_first", a1, 4); check("b2b_second", a2, 9);
        check("b2b_rdata", rdata, 16'h1234);

        // Pulses while busy must be dropped.
        nack = 0; nwe = 0;
        req = 1'b1; we = 1'b0; addr = 20'h00042;
        for (int i = 1; i <= 12; i++) begin
            @(posedge Clk); #1;
            if (ack)  nack++;
            if (!wem) nwe++;
            req = (i == 2 || i == 3); we = 1'b1; addr = 20'h00030; wdata = 16'hDEAD; be = 2'b11;
        end
        check("busy_ign_acks", nack, 1); check("busy_ign_we", nwe, 0);
        check("busy_ign_mem", mem[8'h30], 16'h5530);

        // Reset in the second ACCESS cycle of a write, with req also high.
        req = 1'b1; we = 1'b1; addr = 20'h00050; wdata = 16'h7777; be = 2'b11;
        @(posedge Clk); #1;
        req = 1'b0;
        check("abort_we_started", wem, 0);
        @(posedge Clk); #1;
        Reset = 1'b0; req = 1'b1;
        @(posedge Clk); #1;
        check("abort_ce", ce, 1); check("abort_oe", oe, 1); check("abort_we", wem, 1);
        check("abort_be", mbe, 2'b11); check("abort_data_z", (Data === 16'hzzzz), 1);
        check("abort_ack", ack, 0); check("abort_busy", busy, 0); check("abort_hex", HexOut, 0);
        @(posedge Clk); #1;
        check("rst_over_req", busy, 0);
        Reset = 1'b1; req = 1'b0;
        nack = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge Clk); #1;
            if (ack) nack++;
        end
        check("abort_no_ack", nack, 0);

        run_sweep(1'b1, 18'h00123, 32'h89AB_CDEF, l1, l15, c1, c15, w1, w15, d1, d15);
        check("w1_lat", l1, 3); check("w1_ce", c1, 2); check("w1_we", w1, 1); check("w1_data", d1, 2);
        check("w15_lat", l15, 17); check("w15_ce", c15, 16); check("w15_we", w15, 15);
        check("w15_data", d15, 16);

        run_sweep(1'b0, 18'h0FFFF, 32'h0, l1, l15, c1, c15, w1, w15, d1, d15);
        check("w1_io_lat", l1, 2); check("w15_io_lat", l15, 2);
        check("w1_io_ce", c1, 0); check("w15_io_ce", c15, 0);
        check("w1_io_rdata", s1_rdata, 32'hCAFE_0001); check("w15_io_rdata", s15_rdata, 32'hCAFE_0001);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter DW, default 16: data width; SHALL be a multiple of 8.
REQ-002 Parameter AW, default 20: external SRAM address width.
REQ-003 Parameter WAIT, default 2: SRAM wait cycles per access; SHALL be 1 to 15.
REQ-004 Parameter IO_ADDR, default 'hFFFF: address decoded as memory-mapped I/O.
REQ-005 Port Clk, input, 1: sole clock; all state SHALL update on the rising edge.
REQ-006 Port Reset, input, 1: synchronous, active-low reset.
REQ-007 Port req, input, 1: access request from the CPU.
REQ-008 Port we, input, 1: 1 = write, 0 = read; qualified by req.
REQ-009 Port addr, input, AW: access address.
REQ-010 Port wdata, input, DW: write data.
REQ-011 Port be, input, DW/8: byte enables, active high.
REQ-012 Port rdata, output, DW: registered read data.
REQ-013 Port ack, output, 1: one-cycle completion pulse.
REQ-014 Port busy, output, 1: high from acceptance until ack inclusive.
REQ-015 Port Mem_CE, Mem_OE, Mem_WE, output, 1 each: active-low SRAM strobes.
REQ-016 Port Mem_BE, output, DW/8: active-low byte lanes (UB/LB when DW=16).
REQ-017 Port ADDR, output, AW: registered SRAM address.
REQ-018 Port Data, inout wire, DW: SRAM data bus.
REQ-019 Port Switches, input, DW: switch input returned on I/O reads.
REQ-020 Port HexOut, output, DW: hex display register loaded by I/O writes.

Function
REQ-021 FSM states SHALL be IDLE, ACCESS, IO and DONE.
REQ-022 In IDLE with req=1, the controller SHALL accept the request on that edge and latch addr, we, wdata and be.
REQ-023 An accepted request with addr==IO_ADDR SHALL go to IO; any other address SHALL go to ACCESS with the wait counter loaded to WAIT.
REQ-024 ACCESS SHALL last exactly WAIT+1 cycles, then go to DONE.
REQ-025 During ACCESS: Mem_CE=0; ADDR = latched addr; Mem_BE = ~latched be.
REQ-026 Read in ACCESS: Mem_OE=0 in all cycles; rdata SHALL capture Data on the final ACCESS edge.
REQ-027 Write in ACCESS: Mem_OE=1; Mem_WE=0 in all but the final cycle, and 1 in the final cycle for hold; Data SHALL be driven with the latched wdata in every ACCESS cycle.
REQ-028 Data SHALL be high-impedance in every state except a write ACCESS.
REQ-029 IO read: rdata <= Switches. IO write: HexOut <= wdata, merged per byte using be. IO SHALL then go to DONE after one cycle, and all SRAM strobes SHALL stay high.
REQ-030 DONE SHALL assert ack for exactly one cycle and return to IDLE.
REQ-031 Latency: for SRAM accesses, ack SHALL be high in the cycle WAIT+2 cycles after the accepting edge; for I/O, 2 cycles after it.
REQ-032 req while busy=1 SHALL be ignored; no queuing.
REQ-033 req sampled in DONE SHALL NOT be accepted; the earliest next acceptance is the edge after DONE.
REQ-034 be all-zero SHALL still perform the full bus sequence with Mem_BE all high, and SHALL still produce ack.
REQ-035 All outputs except Data SHALL be registered.

Reset
REQ-036 With Reset=0 at an edge, the block SHALL set: state IDLE; Mem_CE, Mem_OE, Mem_WE, Mem_BE all 1; ADDR 0; rdata 0; HexOut 0; ack 0; busy 0; Data high-impedance.
REQ-037 Reset during ACCESS or IO SHALL abort the access with no ack, and HexOut SHALL be cleared.
REQ-038 Reset SHALL override a simultaneous req.

Structure
REQ-039 The state enum and the strobe-inactive constant SHALL reside in the shared package mem_ctrl_pkg.
REQ-040 The wait counter SHALL be the single sub-module mem_wait_cnt: 4-bit down-counter with ports load, value and done.

Verification
REQ-041 Read: WAIT=2, SRAM model holds 'h1234 at 'h00042; req/we=0/addr='h42/be=2'b11 -> Mem_OE low for 3 cycles, rdata='h1234, ack 4 cycles after acceptance.
REQ-042 Write: wdata='hBEEF, be=2'b01 -> Mem_WE low 2 cycles then high 1 cycle; Mem_BE=2'b10; Data='hBEEF throughout ACCESS; model low byte='hEF.
REQ-043 I/O: Switches='h00A5; read at 'hFFFF -> rdata='h00A5 and ack 2 cycles after acceptance, strobes stay high. Write 'h1234 at 'hFFFF -> HexOut='h1234.
REQ-044 Back-to-back: req held high -> second access accepted on the edge after ack; req pulses while busy are ignored (ack count equals acceptance count).
REQ-045 Reset in the 2nd ACCESS cycle of a write -> next cycle all strobes high, Data Z, no ack, busy 0.
REQ-046 Parameter sweep: DW=32, AW=18, WAIT=1 and WAIT=15 -> latency and strobe widths per REQ-024 and REQ-031.
